// File: rtl/inst_rom_loader.sv
// inst_rom_loader: boot-loaded instruction ROM; holds core in reset while a valid/ready stream fills memory, then serves zero-latency fetches. Ports: clk, rst, ld_valid/ld_ready/ld_data/ld_last (load stream), reload (restart load from RUN), rom_ce_i/rom_addr_i/rom_data_o (fetch), cpu_rst_o, load_done_o, load_cnt_o, overflow_o. Optional INST_ROM_BSWAP_EN byte-reverses words on load.
module inst_rom_loader #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [31:0]       ld_data,
  input  logic              ld_last,
  input  logic              reload,
  input  logic              rom_ce_i,
  input  logic [31:0]       rom_addr_i,
  output logic [31:0]       rom_data_o,
  output logic              cpu_rst_o,
  output logic              load_done_o,
  output logic [ADDR_W:0]   load_cnt_o,
  output logic              overflow_o
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [0:0] S_LOAD = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  logic [0:0]        state_q, state_d;
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic              ovf_q, ovf_d;
  logic [31:0]       mem [DEPTH];
  logic [31:0]       wdata;
  logic [ADDR_W-1:0] idx;
  logic              xfer, full, hit, unused;
  assign ld_ready = (state_q == S_LOAD) && !rst;
  assign xfer = ld_valid && ld_ready;
  assign full = wr_ptr_q == (ADDR_W+1)'(DEPTH - 1);
`ifdef INST_ROM_BSWAP_EN
  assign wdata = {ld_data[7:0], ld_data[15:8], ld_data[23:16], ld_data[31:24]};
`else
  assign wdata = ld_data;
`endif
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    ovf_d    = ovf_q;
    if (state_q == S_RUN) begin
      state_d  = reload ? S_LOAD : S_RUN;
      wr_ptr_d = reload ? '0 : wr_ptr_q;
      ovf_d    = reload ? 1'b0 : ovf_q;
    end else if (xfer) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      state_d  = (ld_last || full) ? S_RUN : S_LOAD;
      ovf_d    = ovf_q || (full && !ld_last);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_LOAD;
      wr_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      ovf_q    <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (xfer) mem[wr_ptr_q[ADDR_W-1:0]] <= wdata;
  end
  // Reads are gated by rst because load count only clears at the reset edge.
  assign idx = rom_addr_i[ADDR_W+1:2];
  assign hit = rom_ce_i && !rst && (rom_addr_i[31:ADDR_W+2] == '0) && ({1'b0, idx} < wr_ptr_q);
  assign rom_data_o  = hit ? mem[idx] : 32'h0;
  assign cpu_rst_o   = state_q == S_LOAD;
  assign load_done_o = state_q == S_RUN;
  assign load_cnt_o  = wr_ptr_q;
  assign overflow_o  = ovf_q;
  assign unused = ^rom_addr_i[1:0];
endmodule

// File: tb/tb_inst_rom_loader.sv
// tb_inst_rom_loader: directed self-checking bench for inst_rom_loader (ADDR_W=10 and ADDR_W=2 instances).
module tb_inst_rom_loader;
  logic clk = 0, rst = 1;
  logic ld_valid = 0, ld_last = 0, reload = 0, rom_ce_i = 0;
  logic [31:0] ld_data = 0, rom_addr_i = 0;
  logic ld_ready, cpu_rst_o, load_done_o, overflow_o;
  logic [31:0] rom_data_o;
  logic [10:0] load_cnt_o;
  logic s_valid = 0, s_last = 0, s_reload = 0, s_ce = 0;
  logic [31:0] s_data = 0, s_addr = 0;
  logic s_ready, s_cpu_rst, s_done, s_ovf;
  logic [31:0] s_rdata;
  logic [2:0] s_cnt;
  int tests = 0, fails = 0;
  logic [31:0] w [4];

  inst_rom_loader #(.ADDR_W(10)) u1 (.clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .reload(reload), .rom_ce_i(rom_ce_i), .rom_addr_i(rom_addr_i),
    .rom_data_o(rom_data_o), .cpu_rst_o(cpu_rst_o), .load_done_o(load_done_o), .load_cnt_o(load_cnt_o),
    .overflow_o(overflow_o));
  inst_rom_loader #(.ADDR_W(2)) u2 (.clk(clk), .rst(rst), .ld_valid(s_valid), .ld_ready(s_ready),
    .ld_data(s_data), .ld_last(s_last), .reload(s_reload), .rom_ce_i(s_ce), .rom_addr_i(s_addr),
    .rom_data_o(s_rdata), .cpu_rst_o(s_cpu_rst), .load_done_o(s_done), .load_cnt_o(s_cnt),
    .overflow_o(s_ovf));

  always #5 clk = ~clk;

  function automatic logic [31:0] bs(input logic [31:0] x);
`ifdef INST_ROM_BSWAP_EN
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
    return x;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    rom_addr_i = a;
    #1;
    chk(tag, rom_data_o, exp);
  endtask

  initial begin
    w[0] = 32'h34010001; w[1] = 32'h34020002; w[2] = 32'h00221820; w[3] = 32'hFFFFFFFF;
    tick(); tick();
    chk("rst_cpu_rst", cpu_rst_o, 1);
    chk("rst_done", load_done_o, 0);
    chk("rst_cnt", load_cnt_o, 0);
    chk("rst_ovf", overflow_o, 0);
    chk("rst_ready", ld_ready, 0);
    rst = 0;
    #1;
    chk("ready_after_rst", ld_ready, 1);
    // test 1: four back-to-back words
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1; ld_data = w[i]; ld_last = (i == 3);
      #1;
      chk($sformatf("t1_ready%0d", i), ld_ready, 1);
      chk($sformatf("t1_cpu_rst%0d", i), cpu_rst_o, 1);
      tick();
    end
    ld_valid = 0; ld_last = 0;
    chk("t1_ready_run", ld_ready, 0);
    chk("t1_cpu_rst", cpu_rst_o, 0);
    chk("t1_done", load_done_o, 1);
    chk("t1_cnt", load_cnt_o, 4);
    chk("t1_ovf", overflow_o, 0);
    // test 2: reads
    rom_ce_i = 1;
    rd(32'h0, bs(w[0]), "t2_a0");
    rd(32'h8, bs(w[2]), "t2_a8");
    rd(32'hA, bs(w[2]), "t2_aA");
    rd(32'hC, bs(w[3]), "t2_aC");
    rd(32'h10, 0, "t2_unloaded");
    rd(32'h1000, 0, "t2_oor");
    rom_ce_i = 0;
    rd(32'h0, 0, "t2_ce_low");
    rom_ce_i = 1;
    // test 4: ADDR_W=2 overflow
    for (int i = 0; i < 5; i++) begin
      s_valid = 1; s_data = 32'hA0 + i; s_last = 0;
      #1;
      chk($sformatf("t4_ready%0d", i), s_ready, (i < 4) ? 1 : 0);
      tick();
      if (i == 3) begin
        chk("t4_ovf", s_ovf, 1);
        chk("t4_cnt", s_cnt, 4);
        chk("t4_done", s_done, 1);
        chk("t4_cpu_rst", s_cpu_rst, 0);
      end
    end
    s_valid = 0;
    chk("t4_cnt_after5", s_cnt, 4);
    s_ce = 1; s_addr = 32'hC;
    #1;
    chk("t4_rd3", s_rdata, bs(32'hA3));
    s_addr = 32'h10;
    #1;
    chk("t4_rd_oor", s_rdata, 0);
    s_reload = 1; tick(); s_reload = 0;
    chk("t4_reload_ovf", s_ovf, 0);
    chk("t4_reload_cnt", s_cnt, 0);
    // test 3: reload then gapped stream 1,0,0,1,1
    reload = 1; tick(); reload = 0;
    chk("t3_reload_cpu_rst", cpu_rst_o, 1);
    chk("t3_reload_done", load_done_o, 0);
    chk("t3_reload_cnt", load_cnt_o, 0);
    ld_valid = 1; ld_data = 32'h11110000; ld_last = 0; tick();
    ld_valid = 0; ld_data = 32'hBAD0BAD0; ld_last = 1; tick();
    ld_data = 32'hBAD1BAD1; tick();
    chk("t3_cnt_idle", load_cnt_o, 1);
    chk("t3_still_load", load_done_o, 0);
    ld_valid = 1; ld_data = 32'h22220000; ld_last = 0; tick();
    ld_data = 32'h33330000; ld_last = 1; tick();
    ld_valid = 0; ld_last = 0;
    chk("t3_cnt", load_cnt_o, 3);
    chk("t3_done", load_done_o, 1);
    rd(32'h0, bs(32'h11110000), "t3_i0");
    rd(32'h4, bs(32'h22220000), "t3_i1");
    rd(32'h8, bs(32'h33330000), "t3_i2");
    rd(32'hC, 0, "t3_i3_unloaded");
    // test 5: reload and single word image
    reload = 1; tick(); reload = 0;
    chk("t5_cpu_rst", cpu_rst_o, 1);
    chk("t5_cnt", load_cnt_o, 0);
    ld_valid = 1; ld_data = 32'hDEADBEEF; ld_last = 1; tick();
    ld_valid = 0; ld_last = 0;
    chk("t5_done", load_done_o, 1);
    rd(32'h0, bs(32'hDEADBEEF), "t5_a0");
    rd(32'h4, 0, "t5_a4");
    // test 6: rst mid-load
    reload = 1; tick(); reload = 0;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1; ld_data = 32'h5000 + i; ld_last = 0; tick();
    end
    ld_valid = 0;
    chk("t6_cnt2", load_cnt_o, 2);
    rst = 1; rom_addr_i = 0;
    #1;
    chk("t6_ready_rst", ld_ready, 0);
    chk("t6_rd_rst", rom_data_o, 0);
    tick();
    rst = 0;
    chk("t6_cnt", load_cnt_o, 0);
    chk("t6_cpu_rst", cpu_rst_o, 1);
    chk("t6_done", load_done_o, 0);
    chk("t6_ovf", overflow_o, 0);
    rd(32'h0, 0, "t6_rd_after_rst");
    // reload ignored in LOAD while a word is accepted
    ld_valid = 1; ld_data = 32'h11223344; ld_last = 1; reload = 1; tick();
    ld_valid = 0; ld_last = 0; reload = 0;
    chk("t6_reload_ignored_cnt", load_cnt_o, 1);
    chk("t6_done2", load_done_o, 1);
    rd(32'h0, bs(32'h11223344), "t6_bswap_rd");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/inst_rom_loader.md
Name: inst_rom_loader

Overview:
Instruction memory with a boot-load front end. It sits directly upstream of the CPU core's fetch port and drives the core's `rom_data_i` from the core's `rom_addr_o`/`rom_ce_o`. After reset it accepts program words over a valid/ready stream, holding the core in reset until loading completes. It then serves zero-latency instruction reads to the core.

Parameters:
ADDR_W, 10, log2 of memory depth in 32-bit words (DEPTH = 2**ADDR_W)

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
ld_valid  in  1  load word valid
ld_ready  out  1  loader can accept a word this cycle
ld_data  in  32  program word
ld_last  in  1  marks final word of the image; qualified by ld_valid&&ld_ready
reload  in  1  single-cycle request to restart loading (honoured only in RUN)
rom_ce_i  in  1  fetch enable from core
rom_addr_i  in  32  fetch byte address from core
rom_data_o  out  32  fetched instruction to core
cpu_rst_o  out  1  reset to core; 1 while not in RUN
load_done_o  out  1  1 while in RUN
load_cnt_o  out  ADDR_W+1  number of words loaded in current image
overflow_o  out  1  sticky: image filled memory without ld_last

Behaviour:
- States:
  - LOAD: reset state.
  - RUN.
- Reset (rst=1 at an edge):
  - state=LOAD, wr_ptr=0, load_cnt_o=0, overflow_o=0, cpu_rst_o=1, load_done_o=0.
  - Memory contents are not cleared.
- ld_ready is combinational and equals (state==LOAD)&&!rst. It is 0 during any rst cycle and throughout RUN.
- Handshake in LOAD:
  - A transfer occurs when ld_valid&&ld_ready at an edge: mem[wr_ptr]<=ld_data, wr_ptr<=wr_ptr+1, load_cnt_o<=load_cnt_o+1.
  - ld_valid may stay high across consecutive cycles, giving 1 word/cycle.
  - ld_data/ld_last are ignored when no transfer occurs.
- LOAD->RUN happens on the edge of a transfer with ld_last=1, or a transfer at wr_ptr==DEPTH-1.
  - If the latter occurs with ld_last=0, overflow_o<=1. overflow_o is sticky until rst or reload.
  - Both ld_last=1 and wr_ptr==DEPTH-1: normal completion, overflow_o stays 0.
- cpu_rst_o and load_done_o are registered:
  - If the final transfer is at edge N, cpu_rst_o=0 and load_done_o=1 from edge N onward.
  - No further words are accepted after edge N.
- RUN->LOAD: reload=1 at an edge in RUN.
  - Sets wr_ptr=0, load_cnt_o=0, overflow_o=0, cpu_rst_o=1, load_done_o=0 at that edge.
  - reload is ignored in LOAD.
  - rst has priority over reload.
- Read path (combinational, zero latency; the core registers it in its IF/ID stage):
  - idx = rom_addr_i[ADDR_W+1:2]. Bits [1:0] are ignored (word-aligned fetch).
  - rom_data_o = mem[idx] if rom_ce_i=1, rom_addr_i[31:ADDR_W+2]==0, and idx<load_cnt_o.
  - Otherwise rom_data_o = 32'h0 (NOP). This covers ce low, out-of-range addresses, unloaded words, and any read during rst.
  - Reads during LOAD follow the same rule. The core is held in reset, so there is no write/read ordering requirement.
- Width rules:
  - load_cnt_o reaches DEPTH exactly on a full image and never wraps.
  - wr_ptr is ADDR_W+1 bits and is not incremented past DEPTH.

Optional Feature:
INST_ROM_BSWAP_EN
- Defined: each accepted ld_data is byte-reversed before storage ({b0,b1,b2,b3}) to load little-endian images.
- Undefined: ld_data is stored unmodified.
- The read path is identical in both cases.

Test Plan:
1. rst 2 cycles, then stream 4 words 0x34010001, 0x34020002, 0x00221820, 0xFFFFFFFF on consecutive cycles, ld_last on the 4th -> ld_ready=1 during the 4 cycles then 0; cpu_rst_o falls and load_done_o rises at the 4th transfer edge; load_cnt_o=4.
2. After test 1, with rom_ce_i=1: addr 0x0 -> 0x34010001; 0x8 -> 0x00221820; 0xA (low bits ignored) -> 0x00221820; 0x10 (unloaded) -> 0; addr 1<<(ADDR_W+2) -> 0; rom_ce_i=0 -> 0.
3. Gapped ld_valid (1,0,0,1,1 with ld_last on the last) -> exactly 3 words stored at indices 0..2 in order; no write on idle cycles.
4. ADDR_W=2: stream 5 words with no ld_last -> 4 accepted, RUN after the 4th, overflow_o=1, load_cnt_o=4, 5th word never accepted (ld_ready=0).
5. In RUN pulse reload -> cpu_rst_o=1, load_cnt_o=0, overflow_o=0 next edge; load 1 word 0xDEADBEEF with ld_last -> addr 0 reads 0xDEADBEEF, addr 4 reads 0.
6. Assert rst mid-load after 2 of 4 words -> all outputs at reset values, ld_ready=0 during rst; addr 0 reads 0 until reloaded. With INST_ROM_BSWAP_EN: load 0x11223344 -> reads 0x44332211.
